// File: rtl/oven_time_clock.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | oven_time_clock: BCD HH:MM time-of-day clock (12 h / 24 h) with prescaled   |
// | minute tick and range-checked set handshake. OVEN_TIME_CLOCK_HEX_EN adds    |
// | active-low seven-segment outputs. Revision: 1.0                             |
// +-----------------------------------------------------------------------------+
module oven_time_clock #(
  parameter int unsigned TICK_DIV = 32'd3000000000,
  parameter int unsigned DIV_W    = 32,
  parameter bit          MODE_24H = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [3:0] set_hour_t,
  input  logic [3:0] set_hour_o,
  input  logic [3:0] set_min_t,
  input  logic [3:0] set_min_o,
  input  logic       set_pm,
  output logic       set_err,
  output logic [3:0] min_o,
  output logic [3:0] min_t,
  output logic [3:0] hour_o,
  output logic [3:0] hour_t,
  output logic       pm,
  output logic       min_pulse,
  output logic       hour_pulse
`ifdef OVEN_TIME_CLOCK_HEX_EN
  ,
  output logic [0:6] hex0,
  output logic [0:6] hex1,
  output logic [0:6] hex2,
  output logic [0:6] hex3
`endif
);

  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic [3:0]       r_min_o, r_min_t, r_hour_o, r_hour_t;
  logic             r_pm, r_min_pulse, r_hour_pulse, r_set_err;

  logic             w_tick, w_set_ok, w_load, w_wrap, w_npm;
  logic [3:0]       w_nmin_o, w_nmin_t, w_nhour_o, w_nhour_t;

  assign set_ready = ~rst;
  assign w_tick    = run && (r_div == c_div_last);
  assign w_load    = set_valid && set_ready && w_set_ok;

  always_comb begin
    w_set_ok = (set_min_o <= 4'd9) && (set_min_t <= 4'd5) && (set_hour_o <= 4'd9);
    if (MODE_24H)
      w_set_ok = w_set_ok && ((set_hour_t < 4'd2) ||
                              (set_hour_t == 4'd2 && set_hour_o <= 4'd3));
    else
      w_set_ok = w_set_ok && ((set_hour_t == 4'd0 && set_hour_o != 4'd0) ||
                              (set_hour_t == 4'd1 && set_hour_o <= 4'd2));
  end

  // Successor of the current time, used only on a tick.
  always_comb begin
    w_nmin_o  = r_min_o + 4'd1;
    w_nmin_t  = r_min_t;
    w_nhour_o = r_hour_o;
    w_nhour_t = r_hour_t;
    w_npm     = r_pm;
    w_wrap    = 1'b0;
    if (r_min_o == 4'd9) begin
      w_nmin_o = 4'd0;
      if (r_min_t == 4'd5) begin
        w_nmin_t = 4'd0;
        w_wrap   = 1'b1;
        if (MODE_24H && r_hour_t == 4'd2 && r_hour_o == 4'd3) begin
          w_nhour_t = 4'd0;
          w_nhour_o = 4'd0;
        end else if (!MODE_24H && r_hour_t == 4'd1 && r_hour_o == 4'd2) begin
          w_nhour_t = 4'd0;
          w_nhour_o = 4'd1;
        end else if (!MODE_24H && r_hour_t == 4'd1 && r_hour_o == 4'd1) begin
          w_nhour_o = 4'd2;
          w_npm     = ~r_pm;
        end else if (r_hour_o == 4'd9) begin
          w_nhour_o = 4'd0;
          w_nhour_t = r_hour_t + 4'd1;
        end else begin
          w_nhour_o = r_hour_o + 4'd1;
        end
      end else begin
        w_nmin_t = r_min_t + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div        <= '0;
      r_min_o      <= 4'd0;
      r_min_t      <= 4'd0;
      r_hour_o     <= MODE_24H ? 4'd0 : 4'd2;
      r_hour_t     <= MODE_24H ? 4'd0 : 4'd1;
      r_pm         <= 1'b0;
      r_min_pulse  <= 1'b0;
      r_hour_pulse <= 1'b0;
      r_set_err    <= 1'b0;
    end else begin
      r_min_pulse  <= 1'b0;
      r_hour_pulse <= 1'b0;
      r_set_err    <= set_valid && !w_set_ok;
      if (w_load) begin
        // A load overrides any coincident tick.
        r_div    <= '0;
        r_min_o  <= set_min_o;
        r_min_t  <= set_min_t;
        r_hour_o <= set_hour_o;
        r_hour_t <= set_hour_t;
        r_pm     <= MODE_24H ? 1'b0 : set_pm;
      end else begin
        if (run)
          r_div <= w_tick ? '0 : r_div + 1'b1;
        if (w_tick) begin
          r_min_o      <= w_nmin_o;
          r_min_t      <= w_nmin_t;
          r_hour_o     <= w_nhour_o;
          r_hour_t     <= w_nhour_t;
          r_pm         <= w_npm;
          r_min_pulse  <= 1'b1;
          r_hour_pulse <= w_wrap;
        end
      end
    end
  end

  assign min_o      = r_min_o;
  assign min_t      = r_min_t;
  assign hour_o     = r_hour_o;
  assign hour_t     = r_hour_t;
  assign pm         = r_pm;
  assign min_pulse  = r_min_pulse;
  assign hour_pulse = r_hour_pulse;
  assign set_err    = r_set_err;

`ifdef OVEN_TIME_CLOCK_HEX_EN
  // Segment order a..g, active low.
  function automatic logic [0:6] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign hex0 = seg7(r_min_o);
  assign hex1 = seg7(r_min_t);
  assign hex2 = seg7(r_hour_o);
  assign hex3 = seg7(r_hour_t);
`endif

endmodule
`default_nettype wire

// File: tb/tb_oven_time_clock.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_oven_time_clock: checks a 24 h and a 12 h instance against a             |
// | minutes-of-day reference model. Revision: 1.0                               |
// +-----------------------------------------------------------------------------+
module tb_oven_time_clock;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic       set_valid = 1'b0;
  logic [3:0] sht = '0, sho = '0, smt = '0, smo = '0;
  logic       spm = 1'b0;

  // Index 0: 24 h instance, index 1: 12 h instance.
  logic       rdy [2];
  logic       err [2];
  logic [3:0] mo [2], mt [2], ho [2], ht [2];
  logic       pmo [2], mp [2], hp [2];
`ifdef OVEN_TIME_CLOCK_HEX_EN
  logic [0:6] hx0 [2], hx1 [2], hx2 [2], hx3 [2];
`endif

  always #5 clk = ~clk;

  oven_time_clock #(.TICK_DIV(TD), .DIV_W(3), .MODE_24H(1'b1)) u_d24 (
    .clk(clk), .rst(rst), .run(run), .set_valid(set_valid), .set_ready(rdy[0]),
    .set_hour_t(sht), .set_hour_o(sho), .set_min_t(smt), .set_min_o(smo),
    .set_pm(spm), .set_err(err[0]), .min_o(mo[0]), .min_t(mt[0]),
    .hour_o(ho[0]), .hour_t(ht[0]), .pm(pmo[0]), .min_pulse(mp[0]),
    .hour_pulse(hp[0])
`ifdef OVEN_TIME_CLOCK_HEX_EN
    , .hex0(hx0[0]), .hex1(hx1[0]), .hex2(hx2[0]), .hex3(hx3[0])
`endif
  );

  oven_time_clock #(.TICK_DIV(TD), .DIV_W(3), .MODE_24H(1'b0)) u_d12 (
    .clk(clk), .rst(rst), .run(run), .set_valid(set_valid), .set_ready(rdy[1]),
    .set_hour_t(sht), .set_hour_o(sho), .set_min_t(smt), .set_min_o(smo),
    .set_pm(spm), .set_err(err[1]), .min_o(mo[1]), .min_t(mt[1]),
    .hour_o(ho[1]), .hour_t(ht[1]), .pm(pmo[1]), .min_pulse(mp[1]),
    .hour_pulse(hp[1])
`ifdef OVEN_TIME_CLOCK_HEX_EN
    , .hex0(hx0[1]), .hex1(hx1[1]), .hex2(hx2[1]), .hex3(hx3[1])
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: time kept as minutes since midnight.
  int div_m [2];
  int mins  [2];
  bit minp [2], hourp [2], errp [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit valid_for(input int k);
    int h;
    h = int'(sht) * 10 + int'(sho);
    if (sho > 9 || smo > 9 || smt > 5) return 1'b0;
    if (k == 0) return h <= 23;
    return h >= 1 && h <= 12;
  endfunction

  function automatic int load_mins(input int k);
    int h, mn;
    h  = int'(sht) * 10 + int'(sho);
    mn = int'(smt) * 10 + int'(smo);
    if (k == 0) return h * 60 + mn;
    return ((h % 12) + (spm ? 12 : 0)) * 60 + mn;
  endfunction

  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin
      div_m[k] = 0; mins[k] = 0;
      minp[k] = 0; hourp[k] = 0; errp[k] = 0;
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      reset_model();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      minp[k] = 0; hourp[k] = 0;
      if (set_valid && valid_for(k)) begin
        mins[k] = load_mins(k); div_m[k] = 0; errp[k] = 0;
      end else begin
        errp[k] = set_valid;
        if (run) begin
          if (div_m[k] == TD - 1) begin
            div_m[k] = 0;
            mins[k]  = (mins[k] + 1) % 1440;
            minp[k]  = 1;
            hourp[k] = (mins[k] % 60) == 0;
          end else begin
            div_m[k]++;
          end
        end
      end
    end
  endtask

  function automatic logic [19:0] exp_vec(input int k);
    int h24, hr, mn;
    h24 = mins[k] / 60;
    mn  = mins[k] % 60;
    hr  = (k == 0) ? h24 : ((h24 % 12 == 0) ? 12 : h24 % 12);
    return {4'(hr / 10), 4'(hr % 10), 4'(mn / 10), 4'(mn % 10),
            (k == 1) && (h24 >= 12), minp[k], hourp[k], errp[k]};
  endfunction

`ifdef OVEN_TIME_CLOCK_HEX_EN
  logic [6:0] seg [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100};
`endif

  task automatic check_all();
    logic [19:0] e;
    for (int k = 0; k < 2; k++) begin
      e = exp_vec(k);
      chk(k == 0 ? "state24" : "state12",
          32'({ht[k], ho[k], mt[k], mo[k], pmo[k], mp[k], hp[k], err[k]}), 32'(e));
      chk(k == 0 ? "ready24" : "ready12", 32'(rdy[k]), 32'(!rst));
`ifdef OVEN_TIME_CLOCK_HEX_EN
      chk(k == 0 ? "hex24" : "hex12", 32'({hx3[k], hx2[k], hx1[k], hx0[k]}),
          32'({seg[e[19:16]], seg[e[15:12]], seg[e[11:8]], seg[e[7:4]]}));
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  typedef struct {
    logic [3:0]  ht, ho, mt, mo;
    logic        p;
    bit          ok24, ok12;
    logic [15:0] a24;   // 24 h time one tick after the load
    logic [16:0] a12;   // 12 h time and pm one tick after the load
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{4'd2, 4'd3, 4'd5, 4'd9, 1'b0, 1'b1, 1'b0, 16'h0000, 17'h0};
    tbl[1]  = '{4'd1, 4'd1, 4'd5, 4'd9, 1'b0, 1'b1, 1'b1, 16'h1200, {16'h1200, 1'b1}};
    tbl[2]  = '{4'd1, 4'd2, 4'd5, 4'd9, 1'b1, 1'b1, 1'b1, 16'h1300, {16'h0100, 1'b1}};
    tbl[3]  = '{4'd2, 4'd4, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 17'h0};
    tbl[4]  = '{4'd0, 4'd0, 4'd3, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0031, 17'h0};
    tbl[5]  = '{4'd1, 4'd0, 4'd6, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 17'h0};
    tbl[6]  = '{4'd0, 4'd10, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 17'h0};
    tbl[7]  = '{4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b1, 1'b1, 16'h1235, {16'h1235, 1'b0}};
    tbl[8]  = '{4'd0, 4'd9, 4'd5, 4'd9, 1'b1, 1'b1, 1'b1, 16'h1000, {16'h1000, 1'b1}};
    tbl[9]  = '{4'd1, 4'd1, 4'd5, 4'd9, 1'b1, 1'b1, 1'b1, 16'h1200, {16'h1200, 1'b0}};
    tbl[10] = '{4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0001, 17'h0};

    // Power-on reset.
    #1 rst = 1'b1;
    #1 reset_model();
    check_all();
    chk("rst_t12", 32'({ht[1], ho[1], mt[1], mo[1], pmo[1]}), 32'({16'h1200, 1'b0}));
    step(); step();
    rst = 1'b0;
    run = 1'b1;

    // Free run for 60 ticks: 01:00 with hour_pulse on the last edge.
    for (int i = 0; i < 60 * TD; i++) step();
    chk("t0100", 32'({ht[0], ho[0], mt[0], mo[0], hp[0]}), 32'({16'h0100, 1'b1}));

    // Table of loads, each followed by exactly one tick.
    foreach (tbl[i]) begin
      run = 1'b0;
      {sht, sho, smt, smo, spm} = {tbl[i].ht, tbl[i].ho, tbl[i].mt, tbl[i].mo, tbl[i].p};
      set_valid = 1'b1;
      step();
      set_valid = 1'b0;
      chk("ld_err24", 32'(err[0]), 32'(!tbl[i].ok24));
      chk("ld_err12", 32'(err[1]), 32'(!tbl[i].ok12));
      if (tbl[i].ok24)
        chk("ld_t24", 32'({ht[0], ho[0], mt[0], mo[0]}),
            32'({tbl[i].ht, tbl[i].ho, tbl[i].mt, tbl[i].mo}));
      if (tbl[i].ok12)
        chk("ld_t12", 32'({ht[1], ho[1], mt[1], mo[1], pmo[1]}),
            32'({tbl[i].ht, tbl[i].ho, tbl[i].mt, tbl[i].mo, tbl[i].p}));
`ifdef OVEN_TIME_CLOCK_HEX_EN
      if (i == 7)
        chk("hex1234", 32'({hx3[0], hx2[0], hx1[0], hx0[0]}),
            32'({7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}));
`endif
      run = 1'b1;
      for (int j = 0; j < TD; j++) step();
      if (tbl[i].ok24)
        chk("tick24", 32'({ht[0], ho[0], mt[0], mo[0]}), 32'(tbl[i].a24));
      if (tbl[i].ok12)
        chk("tick12", 32'({ht[1], ho[1], mt[1], mo[1], pmo[1]}), 32'(tbl[i].a12));
    end

    // Load coinciding with the prescaler wrap.
    run = 1'b1;
    for (int i = 0; i < 8 && div_m[0] != TD - 1; i++) step();
    {sht, sho, smt, smo, spm} = {4'd1, 4'd0, 4'd1, 4'd5, 1'b0};
    set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    chk("coll_ld", 32'({ht[0], ho[0], mt[0], mo[0], mp[0], hp[0]}), 32'({16'h1015, 2'b00}));
    for (int i = 0; i < TD - 1; i++) step();
    chk("coll_wait", 32'({ht[0], ho[0], mt[0], mo[0], mp[0]}), 32'({16'h1015, 1'b0}));
    step();
    chk("coll_tick", 32'({ht[0], ho[0], mt[0], mo[0], mp[0]}), 32'({16'h1016, 1'b1}));

    // Hold with the prescaler parked at 2.
    step(); step();
    run = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("hold", 32'({ht[0], ho[0], mt[0], mo[0], mp[0]}), 32'({16'h1016, 1'b0}));
    run = 1'b1;
    step();
    chk("resume1", 32'({ht[0], ho[0], mt[0], mo[0], mp[0]}), 32'({16'h1016, 1'b0}));
    step();
    chk("resume2", 32'({ht[0], ho[0], mt[0], mo[0], mp[0]}), 32'({16'h1017, 1'b1}));

    // Asynchronous reset between edges.
    #3 rst = 1'b1;
    #1 reset_model();
    check_all();
    chk("arst24", 32'({ht[0], ho[0], mt[0], mo[0], mp[0]}), 32'({16'h0000, 1'b0}));
    step(); step();
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      run = ($urandom_range(0, 7) != 0);
      set_valid = ($urandom_range(0, 15) == 0);
      sht = 4'($urandom_range(0, 3));
      sho = 4'($urandom_range(0, 10));
      smt = 4'($urandom_range(0, 6));
      smo = 4'($urandom_range(0, 10));
      spm = 1'($urandom_range(0, 1));
      for (int k = 0; k < 2; k++)
        if (set_valid && !valid_for(k) && run && div_m[k] == TD - 1) set_valid = 1'b0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
